seg7_scan_display: RTL
======================

# seg7_scan_display

Four-digit multiplexed seven-segment display driver downstream of the processor top level. Consumes the 16-bit `test` word driven out of data memory and shows it as four hexadecimal digits. Filters transient values so only stable results reach the display, and time-multiplexes the digits onto one shared segment bus.

## Interface

**Parameters**
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal minimum 2.
- `HOLD_CYCLES`, default 4: consecutive equal samples `test_in` must show before it is displayed; legal minimum 1.
- `BLANK_LZ`, default 1: when 1, leading zero digits are blanked.

**Ports**
- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `test_in`, input, 16: value to display; connects to `test`.
- `freeze`, input, 1: when 1, the displayed value is held and new values are ignored.
- `an`, output, 4: digit enables, one-hot active-low. `an[0]` is the rightmost digit.
- `seg`, output, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`, output, 1: decimal point, active-low.
- `upd`, output, 1: one-cycle pulse when the displayed value changes.

## Operation

**Stability filter**
- Registers `last_in[15:0]` and `stab_cnt`, saturating at `HOLD_CYCLES`.
- Every edge, `last_in <= test_in`.
- If `test_in != last_in`, then `stab_cnt <= 0`. Otherwise `stab_cnt` increments, saturating at `HOLD_CYCLES`.

**Display load**
- Load condition: `stab_cnt == HOLD_CYCLES`, `freeze == 0`, and `last_in != disp_val`.
- When the condition holds, `disp_val <= last_in` and `upd <= 1`. Otherwise `upd <= 0`.
- While `freeze` is 1, the filter keeps tracking `test_in`.
- When `freeze` falls, a pending stable value loads on the first following edge.

**Scan**
- Prescaler `pre` counts 0 to `REFRESH_DIV-1`, then wraps to 0.
- On wrap, digit index `idx` advances 0→1→2→3→0.
- Digit `i` shows nibble `disp_val[4i+3:4i]`.

**Hex decode** (active-low `gfedcba`)
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

**Blanking**
- Applies only when `BLANK_LZ=1`.
- Digit `i ≥ 1` is blanked when every nibble at positions `≥ i` is zero.
- A blanked digit drives `seg=7'h7F` and `an=4'hF`.
- Digit 0 is never blanked.

**Decimal point**
- `dp=0` only while `idx==0` and `freeze==1`, marking frozen state. Otherwise `dp=1`.

**Output registers**
- `an`, `seg`, `dp` and `upd` are registered, giving glitch-free pins.
- `an`, `seg` and `dp` are computed from the current `idx`, `disp_val` and `freeze`, so they lag those values by one cycle.

**Reset** (the whole block returns to these values on any edge with `Reset=1`, including mid-scan and mid-filter)
- `last_in=0`, `stab_cnt=0`, `disp_val=0`, `pre=0`, `idx=0`.
- `an=4'b1110`, `seg=7'b1000000` (digit "0"), `dp=1`, `upd=0`.

## Timing

- **Filter latency:** `test_in` first sampled with new value V at edge t, then held.
  - `stab_cnt` reaches `HOLD_CYCLES` after edge t+`HOLD_CYCLES`.
  - `disp_val=V` and `upd=1` after edge t+`HOLD_CYCLES`+1.
  - `an`/`seg` reflect V one edge later.
- **Glitch rejection:** any change of `test_in` before the load edge restarts the count from the new value. A value held for fewer than `HOLD_CYCLES`+1 samples never displays.
- **Re-presenting the shown value:** a stable `test_in` equal to `disp_val` produces no load and no `upd` pulse.
- **Digit dwell:** exactly `REFRESH_DIV` cycles per digit; one frame is 4×`REFRESH_DIV` cycles.
- **`idx` wrap:** 3→0 on the wrap of `pre`.
- **Simultaneous load and digit advance:** both happen on the same edge. The next output update uses the new `idx` with the new `disp_val`.
- **`upd` width:** exactly one cycle. It can re-pulse at the earliest `HOLD_CYCLES`+1 cycles later.

## Test plan

1. **Reset values.** `REFRESH_DIV=4`, `HOLD_CYCLES=3`; assert `Reset` for 2 cycles → `an=1110`, `seg=1000000`, `dp=1`, `upd=0`. Then `an` steps 1110 with digits 1–3 blanked (`an=1111`, `seg=7F`), each 4 cycles.
2. **Load and full decode.** Hold `test_in=16'h1A2F` → `upd` pulses once, exactly 4 edges after the first sample. Over one frame, digits 0..3 show F=0001110, 2=0100100, A=0001000, 1=1111001.
3. **Glitch rejection.** From display 1A2F, drive `16'h0005` for 2 cycles then back to `16'h1A2F` → no `upd` and display unchanged. Then hold `16'h0005` → after load, digits 1–3 blanked and digit 0 shows 0010010.
4. **Freeze.** `freeze=1`, hold `16'hBEEF` for 20 cycles → display unchanged and `dp=0` only during digit-0 slots. Drop `freeze` → `upd` on the next edge, display `BEEF`.
5. **Blanking disabled and mid-operation reset.** With `BLANK_LZ=0`, `test_in=16'h0000` → all four digits show 1000000. `Reset` asserted for 1 cycle mid-scan at `idx=2` → the next cycle matches scenario 1's reset values.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display driver with a stability filter on the input word.
// Only values held steady long enough reach the display; digits are time-multiplexed onto one segment bus.
module seg7_scan_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int HOLD_CYCLES = 4,
   parameter int BLANK_LZ    = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] test_in,
   input  logic        freeze,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        upd
);

   localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES);

   logic [15:0]      last_in;
   logic [CNT_W-1:0] stab_cnt;
   logic [15:0]      disp_val;
   logic [PRE_W-1:0] pre;
   logic [1:0]       idx;

   logic             load;
   logic             pre_wrap;
   logic [3:0]       nibble;
   logic             blank;
   logic [3:0]       an_next;
   logic [6:0]       seg_next;
   logic             dp_next;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // stab_cnt counts consecutive identical samples, saturating at HOLD_CYCLES
   always_ff @(posedge Clk) begin
      if (Reset) begin
         last_in  <= '0;
         stab_cnt <= '0;
      end else begin
         last_in <= test_in;
         if (test_in != last_in)
            stab_cnt <= '0;
         else if (stab_cnt != CNT_MAX)
            stab_cnt <= stab_cnt + CNT_W'(1);
      end
   end

   assign load = (stab_cnt == CNT_MAX) && !freeze && (last_in != disp_val);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         disp_val <= '0;
         upd      <= 1'b0;
      end else begin
         upd <= load;
         if (load)
            disp_val <= last_in;
      end
   end

   assign pre_wrap = (pre == PRE_LAST);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= pre_wrap ? '0 : pre + PRE_W'(1);
         if (pre_wrap)
            idx <= idx + 2'd1;
      end
   end

   // A digit is a leading zero when it and every more significant nibble are zero
   always_comb begin
      blank = 1'b0;
      if (BLANK_LZ != 0) begin
         case (idx)
            2'd1:    blank = (disp_val[15:4] == 12'h000);
            2'd2:    blank = (disp_val[15:8] == 8'h00);
            2'd3:    blank = (disp_val[15:12] == 4'h0);
            default: blank = 1'b0;
         endcase
      end
   end

   always_comb begin
      nibble   = disp_val[{idx, 2'b00} +: 4];
      an_next  = ~(4'b0001 << idx);
      seg_next = hex7(nibble);
      dp_next  = !((idx == 2'd0) && freeze);
      if (blank) begin
         an_next  = 4'hF;
         seg_next = 7'h7F;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         an  <= 4'b1110;
         seg <= 7'b1000000;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule
